// File: rtl/act_mem_arb_pkg.sv
// rtl/act_mem_arb_pkg.sv - shared types and default widths for the activation memory arbiter
// Purpose: arbiter FSM state type plus default address/data widths, which
//          track the activation memory parameters.
package act_mem_arb_pkg;

  // Activation memory geometry: 4K words, bank = address MSB, N_DIM_ARRAY=4 bytes per word.
  localparam int ACT_ADDR_W = 12;
  localparam int ACT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/act_mem_arb_perf.sv
// rtl/act_mem_arb_perf.sv - saturating conflict / forced-grant event counters
// Purpose: two 32-bit saturating event counters for arbiter profiling.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   perf_clr              synchronous clear, wins over increment
//   inc_conflict          host request blocked this cycle
//   inc_force             arbiter in forced-grant cycle
//   perf_conflict_cnt     blocked-cycle count
//   perf_force_cnt        forced-grant cycle count
module act_mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        perf_clr,
  input  logic        inc_conflict,
  input  logic        inc_force,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_force_cnt
);

  logic [31:0] r_conflict_cnt;
  logic [31:0] r_force_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else if (perf_clr) begin
      r_conflict_cnt <= '0;
      r_force_cnt    <= '0;
    end else begin
      if (inc_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (inc_force && (r_force_cnt != '1))       r_force_cnt    <= r_force_cnt + 32'd1;
    end
  end

  assign perf_conflict_cnt = r_conflict_cnt;
  assign perf_force_cnt    = r_force_cnt;

endmodule

// File: rtl/act_mem_arbiter.sv
// rtl/act_mem_arbiter.sv - activation memory bank-slot arbiter between host port and MAC engine
// Purpose: engine accesses win a bank slot; a host request blocked for
//          MAX_WAIT+1 cycles gets a forced slot while the engine is stalled.
//          Host read data returns one cycle after its grant.
// Optional: ACT_MEM_ARB_PERF_EN adds perf_clr / perf_conflict_cnt / perf_force_cnt.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   host_req/we/addr/wdata              host access request (held until granted)
//   host_gnt                            host access accepted this cycle
//   host_rvalid/rdata                   host read return
//   eng_rd_req/bank, eng_wr_req/bank    engine accesses this cycle
//   eng_stall                           engine must hold its request
//   mem_rd_en, mem_wr_en                gated engine enables
//   mem_rd_en_ext, mem_wr_en_ext        host strobes to memory
//   mem_addr_ext, mem_wr_data_ext       host address / write data
//   mem_rd_data_ext                     memory host read data (1-cycle latency)
module act_mem_arbiter
  import act_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ACT_ADDR_W,
  parameter int DATA_W   = ACT_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              eng_rd_req,
  input  logic              eng_rd_bank,
  input  logic              eng_wr_req,
  input  logic              eng_wr_bank,
  output logic              eng_stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en_ext,
  output logic              mem_wr_en_ext,
  output logic [ADDR_W-1:0] mem_addr_ext,
  output logic [DATA_W-1:0] mem_wr_data_ext,
  input  logic [DATA_W-1:0] mem_rd_data_ext
`ifdef ACT_MEM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_force_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rd_pend;

  logic w_hb;
  logic w_conflict;
  logic w_force;
  logic w_gnt;

  assign w_hb       = host_addr[ADDR_W-1];
  // Read and write to the host bank together still count as one conflict.
  assign w_conflict = host_req & ((eng_rd_req & (eng_rd_bank == w_hb)) |
                                  (eng_wr_req & (eng_wr_bank == w_hb)));
  assign w_force    = (r_state == FORCE);

  always_comb begin
    w_gnt = 1'b0;
    case (r_state)
      IDLE, WAIT: w_gnt = host_req & ~w_conflict;
      FORCE:      w_gnt = host_req;
      default:    w_gnt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt & ~host_we;
      case (r_state)
        IDLE: begin
          if (w_conflict) begin
            r_state    <= WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          // A dropped request is a protocol violation; just abandon the wait.
          if (!host_req || !w_conflict) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == CNT_W'(MAX_WAIT)) begin
            r_state <= FORCE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        FORCE: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign host_gnt        = w_gnt;
  assign eng_stall       = w_force;
  // Only the host's bank is taken away from the engine during a forced slot.
  assign mem_rd_en       = eng_rd_req & ~(w_force & (eng_rd_bank == w_hb));
  assign mem_wr_en       = eng_wr_req & ~(w_force & (eng_wr_bank == w_hb));
  assign mem_rd_en_ext   = w_gnt & ~host_we;
  assign mem_wr_en_ext   = w_gnt & host_we;
  assign mem_addr_ext    = w_gnt ? host_addr : '0;
  assign mem_wr_data_ext = w_gnt ? host_wdata : '0;
  assign host_rvalid     = r_rd_pend;
  assign host_rdata      = r_rd_pend ? mem_rd_data_ext : '0;

`ifdef ACT_MEM_ARB_PERF_EN
  act_mem_arb_perf u_perf (
    .clk               (clk),
    .reset             (reset),
    .perf_clr          (perf_clr),
    .inc_conflict      (host_req & ~w_gnt),
    .inc_force         (w_force),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_force_cnt    (perf_force_cnt)
  );
`endif

endmodule

// File: tb/tb_act_mem_arbiter.sv
// tb/tb_act_mem_arbiter.sv - self-checking bench for act_mem_arbiter
module tb_act_mem_arbiter;
  import act_mem_arb_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 15;

  logic              clk;
  logic              reset;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              eng_rd_req;
  logic              eng_rd_bank;
  logic              eng_wr_req;
  logic              eng_wr_bank;
  logic              eng_stall;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              mem_rd_en_ext;
  logic              mem_wr_en_ext;
  logic [ADDR_W-1:0] mem_addr_ext;
  logic [DATA_W-1:0] mem_wr_data_ext;
  logic [DATA_W-1:0] mem_rd_data_ext;
`ifdef ACT_MEM_ARB_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_conflict_cnt;
  logic [31:0]       perf_force_cnt;
`endif

  act_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .host_req        (host_req),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_gnt        (host_gnt),
    .host_rvalid     (host_rvalid),
    .host_rdata      (host_rdata),
    .eng_rd_req      (eng_rd_req),
    .eng_rd_bank     (eng_rd_bank),
    .eng_wr_req      (eng_wr_req),
    .eng_wr_bank     (eng_wr_bank),
    .eng_stall       (eng_stall),
    .mem_rd_en       (mem_rd_en),
    .mem_wr_en       (mem_wr_en),
    .mem_rd_en_ext   (mem_rd_en_ext),
    .mem_wr_en_ext   (mem_wr_en_ext),
    .mem_addr_ext    (mem_addr_ext),
    .mem_wr_data_ext (mem_wr_data_ext),
    .mem_rd_data_ext (mem_rd_data_ext)
`ifdef ACT_MEM_ARB_PERF_EN
    ,
    .perf_clr          (perf_clr),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_force_cnt    (perf_force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: counts how many cycles the current host request has gone unserved.
  // Once that count exceeds MAX_WAIT the host must own its bank this cycle.
  int          m_blocked;
  logic        m_pend;
  logic        m_hb, m_conf, m_forced;
  logic        e_gnt, e_stall, e_rd_en, e_wr_en;

  always_comb begin
    m_hb     = host_addr[ADDR_W-1];
    m_conf   = host_req && ((eng_rd_req && eng_rd_bank == m_hb) || (eng_wr_req && eng_wr_bank == m_hb));
    m_forced = host_req && (m_blocked > MAX_WAIT);
    e_gnt    = host_req && (!m_conf || m_forced);
    e_stall  = m_forced;
    e_rd_en  = eng_rd_req && !(m_forced && eng_rd_bank == m_hb);
    e_wr_en  = eng_wr_req && !(m_forced && eng_wr_bank == m_hb);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_blocked <= 0;
      m_pend    <= 1'b0;
    end else begin
      m_pend    <= e_gnt && !host_we;
      m_blocked <= (e_gnt || !host_req) ? 0 : m_blocked + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_gnt",    host_gnt,      e_gnt);
    chk("m_stall",  eng_stall,     e_stall);
    chk("m_rd_en",  mem_rd_en,     e_rd_en);
    chk("m_wr_en",  mem_wr_en,     e_wr_en);
    chk("m_rd_ext", mem_rd_en_ext, e_gnt && !host_we);
    chk("m_wr_ext", mem_wr_en_ext, e_gnt && host_we);
    chk("m_addr",   mem_addr_ext,  e_gnt ? host_addr : '0);
    chk("m_wdata",  mem_wr_data_ext, e_gnt ? host_wdata : '0);
    chk("m_rvalid", host_rvalid,   m_pend);
    chk("m_rdata",  host_rdata,    m_pend ? mem_rd_data_ext : '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    mem_rd_data_ext = 32'hD000_0000 | 32'(cyc);
  endtask

  task automatic idle_inputs();
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_rd_req = 1'b0; eng_rd_bank = 1'b0; eng_wr_req = 1'b0; eng_wr_bank = 1'b0;
  endtask

  // Leaves the bench at the negedge of the grant cycle; at = cycles waited (-1 on timeout).
  task automatic wait_grant(input int limit, output int at);
    at = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (host_gnt) begin
        at = c;
        c  = limit;
      end else begin
        step();
      end
    end
  endtask

  int at;

  initial begin
    reset = 1'b0;
    idle_inputs();
    mem_rd_data_ext = '0;
`ifdef ACT_MEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    step(); step();
    @(negedge clk);
    chk("rst_gnt",    host_gnt, 1'b0);
    chk("rst_rvalid", host_rvalid, 1'b0);
    chk("rst_stall",  eng_stall, 1'b0);
    chk("rst_state",  dut.r_state, IDLE);
    chk("rst_cnt",    dut.r_wait_cnt, 0);
    step();
    reset = 1'b1;

    // Host write, engine idle: immediate grant.
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h005; host_wdata = 32'hA5A5_0001;
    @(negedge clk);
    chk("wr_gnt",   host_gnt, 1'b1);
    chk("wr_ext",   mem_wr_en_ext, 1'b1);
    chk("wr_addr",  mem_addr_ext, 12'h005);
    chk("wr_data",  mem_wr_data_ext, 32'hA5A5_0001);
    step();
    idle_inputs();
    @(negedge clk);
    chk("wr_norvalid", host_rvalid, 1'b0);

    // Host read bank 1 while engine reads bank 0.
    step();
    host_req = 1'b1; host_addr = 12'h805; eng_rd_req = 1'b1; eng_rd_bank = 1'b0;
    @(negedge clk);
    chk("rd1_gnt",   host_gnt, 1'b1);
    chk("rd1_rdext", mem_rd_en_ext, 1'b1);
    chk("rd1_engrd", mem_rd_en, 1'b1);
    step();
    host_req = 1'b0;
    mem_rd_data_ext = 32'hCAFE_0805;
    @(negedge clk);
    chk("rd1_rvalid", host_rvalid, 1'b1);
    chk("rd1_rdata",  host_rdata, 32'hCAFE_0805);

    // Engine hammers bank 0 for reads and bank 1 for writes; host reads 0x010.
    step();
    host_req = 1'b1; host_addr = 12'h010; eng_rd_req = 1'b1; eng_rd_bank = 1'b0;
    eng_wr_req = 1'b1; eng_wr_bank = 1'b1;
    wait_grant(20, at);
    chk("force_cycle",   at, 16);
    chk("force_stall",   eng_stall, 1'b1);
    chk("force_rdgate",  mem_rd_en, 1'b0);
    chk("force_otherwr", mem_wr_en, 1'b1);
    step();
    host_req = 1'b0;
    @(negedge clk);
    chk("force_cnt0",   dut.r_wait_cnt, 0);
    chk("force_1cyc",   eng_stall, 1'b0);
    chk("force_rd_on",  mem_rd_en, 1'b1);
    chk("force_rvalid", host_rvalid, 1'b1);
    step();
    idle_inputs();

    // Engine write on bank 1 releases at cycle 3.
    step();
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h8AA; host_wdata = 32'h1234_5678;
    eng_wr_req = 1'b1; eng_wr_bank = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rel_blocked", host_gnt, 1'b0);
      step();
    end
    eng_wr_req = 1'b0;
    @(negedge clk);
    chk("rel_gnt",   host_gnt, 1'b1);
    chk("rel_stall", eng_stall, 1'b0);
    step();
    idle_inputs();

    // Engine read and write both on the host bank: a forced grant gates both.
    step();
    host_req = 1'b1; host_addr = 12'h001;
    eng_rd_req = 1'b1; eng_rd_bank = 1'b0; eng_wr_req = 1'b1; eng_wr_bank = 1'b0;
    wait_grant(20, at);
    chk("both_cycle", at, 16);
    chk("both_rd",    mem_rd_en, 1'b0);
    chk("both_wr",    mem_wr_en, 1'b0);
    step();
    idle_inputs();

    // Request dropped while waiting, then re-issued with no conflict.
    step();
    host_req = 1'b1; host_addr = 12'h002; eng_rd_req = 1'b1;
    step(); step(); step();
    host_req = 1'b0;
    @(negedge clk);
    chk("drop_state", dut.r_state, WAIT);
    step();
    @(negedge clk);
    chk("drop_idle", dut.r_state, IDLE);
    chk("drop_cnt",  dut.r_wait_cnt, 0);
    eng_rd_req = 1'b0;
    step();
    host_req = 1'b1;
    @(negedge clk);
    chk("drop_regnt", host_gnt, 1'b1);

    // Back-to-back host reads.
    step();
    host_addr = 12'h820;
    step();
    host_addr = 12'h821;
    @(negedge clk);
    chk("b2b_gnt2",    host_gnt, 1'b1);
    chk("b2b_rvalid1", host_rvalid, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("b2b_rvalid2", host_rvalid, 1'b1);
    chk("b2b_rdata2",  host_rdata, mem_rd_data_ext);

    // Reset the cycle after a granted read.
    step();
    host_req = 1'b1; host_addr = 12'h100;
    step();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid", host_rvalid, 1'b0);
    chk("rstrd_state",  dut.r_state, IDLE);
    step();
    reset = 1'b1;

`ifdef ACT_MEM_ARB_PERF_EN
    step();
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    host_req = 1'b1; host_addr = 12'h003; eng_rd_req = 1'b1;
    for (int c = 0; c < 5; c++) step();
    idle_inputs();
    @(negedge clk);
    chk("perf_conf5",  perf_conflict_cnt, 32'd5);
    chk("perf_force0", perf_force_cnt, 32'd0);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    @(negedge clk);
    chk("perf_clr", perf_conflict_cnt, 32'd0);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
